// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared fetch-stage types and constants
// Purpose: fetch FSM encoding, next-PC select codes, reset PC default,
//          PC step and word-alignment helpers used by the fetch stage.
package if_fetch_stage_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_HOLD     = 2'd0,
    SEL_INC      = 2'd1,
    SEL_REDIRECT = 2'd2,
    SEL_PEND     = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_pc_next.sv
// rtl/if_pc_next.sv - combinational next-PC select
// Purpose: picks hold / increment / redirect / pending-redirect as next PC.
// Ports:
//   pc          in  32  current PC
//   sel         in   2  next-PC source select
//   redirect_pc in  32  redirect target (low two bits dropped here)
//   pend_pc     in  32  stored pending redirect target (already aligned)
//   pc_inc      out 32  pc + PC_STEP, wraps mod 2^32
//   pc_next     out 32  selected next PC
module if_pc_next
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0] pc,
  input  pc_sel_e     sel,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] pend_pc,
  output logic [31:0] pc_inc,
  output logic [31:0] pc_next
);

  assign pc_inc = pc + 32'(PC_STEP);

  always_comb begin
    pc_next = pc;
    case (sel)
      SEL_INC:      pc_next = pc_inc;
      SEL_REDIRECT: pc_next = align_pc(redirect_pc);
      SEL_PEND:     pc_next = pend_pc;
      default:      pc_next = pc;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage feeding the IF/ID register
// Purpose: owns the PC, drives the instruction cache, handles misses, stalls
//          and redirects (including a redirect arriving during a miss).
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   stall            hold PC, present no instruction
//   redirect_valid   taken branch/jump this cycle, redirect_pc its target
//   imem_addr/req    fetch address (= PC) and request (= ~stall out of reset)
//   imem_rdata/hit   same-cycle cache response
//   adder_out        PC + PC_STEP to IF/ID
//   instruction_out  fetched word to IF/ID, valid when hit_out
//   miss_count       saturating count of RUN->MISS transitions
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_hit,
  output logic [31:0] adder_out,
  output logic [31:0] instruction_out,
  output logic        hit_out,
  output logic [31:0] miss_count
);

  fetch_state_e state, state_next;
  pc_sel_e      sel;
  logic [31:0]  pc, pc_next, pend_pc;
  logic         pend_valid, pend_set, count_inc;

  if_pc_next #(.PC_STEP(PC_STEP)) u_pc_next (
    .pc          (pc),
    .sel         (sel),
    .redirect_pc (redirect_pc),
    .pend_pc     (pend_pc),
    .pc_inc      (adder_out),
    .pc_next     (pc_next)
  );

  assign imem_addr       = pc;
  assign imem_req        = rstn & ~stall;
  assign instruction_out = imem_rdata;
  // A pending redirect means the line being filled is on the wrong path.
  assign hit_out = rstn & imem_hit & ~stall & ~redirect_valid & ~pend_valid;

  always_comb begin
    state_next = state;
    sel        = SEL_HOLD;
    pend_set   = 1'b0;
    count_inc  = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect_valid)  sel = SEL_REDIRECT;
        else if (stall)      sel = SEL_HOLD;
        else if (imem_hit)   sel = SEL_INC;
        else begin
          state_next = ST_MISS;
          count_inc  = 1'b1;
        end
      end
      ST_MISS: begin
        if (!imem_hit) begin
          // PC stays on the missing line; remember the latest redirect.
          pend_set = redirect_valid;
        end else begin
          state_next = ST_RUN;
          if (redirect_valid)  sel = SEL_REDIRECT;
          else if (pend_valid) sel = SEL_PEND;
          else if (!stall)     sel = SEL_INC;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (pend_set) begin
        pend_valid <= 1'b1;
        pend_pc    <= align_pc(redirect_pc);
      end else if (state == ST_MISS && imem_hit) begin
        pend_valid <= 1'b0;
      end
      if (count_inc && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_hit = 1'b0;
  logic [31:0] imem_addr, adder_out, instruction_out, miss_count;
  logic        imem_req, hit_out;

  int checks = 0;
  int errors = 0;

  // Reference model: where the fetch is, whether a miss is outstanding,
  // and the redirect target waiting for the fill.
  logic [31:0] m_pc, m_pend_pc, m_cnt;
  bit          m_missing, m_pend;

  if_fetch_stage #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_addr       (imem_addr),
    .imem_req        (imem_req),
    .imem_rdata      (imem_rdata),
    .imem_hit        (imem_hit),
    .adder_out       (adder_out),
    .instruction_out (instruction_out),
    .hit_out         (hit_out),
    .miss_count      (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = RST_PC; m_pend_pc = 32'h0; m_cnt = 32'h0; m_missing = 0; m_pend = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic exp_hit;
    exp_hit = imem_hit && !stall && !redirect_valid && !m_pend;
    check32({tag, ".addr"},  imem_addr, m_pc);
    check32({tag, ".req"},   {31'b0, imem_req}, {31'b0, !stall});
    check32({tag, ".adder"}, adder_out, m_pc + 32'd4);
    check32({tag, ".instr"}, instruction_out, imem_rdata);
    check32({tag, ".hit"},   {31'b0, hit_out}, {31'b0, exp_hit});
    check32({tag, ".cnt"},   miss_count, m_cnt);
  endtask

  task automatic model_clock();
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    if (!m_missing) begin
      if (redirect_valid)  m_pc = tgt;
      else if (stall)      m_pc = m_pc;
      else if (imem_hit)   m_pc = m_pc + 32'd4;
      else begin
        m_missing = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
    end else if (!imem_hit) begin
      if (redirect_valid) begin m_pend = 1; m_pend_pc = tgt; end
    end else begin
      m_missing = 0;
      if (redirect_valid) m_pc = tgt;
      else if (m_pend)    m_pc = m_pend_pc;
      else if (!stall)    m_pc = m_pc + 32'd4;
      m_pend = 0;
    end
  endtask

  task automatic step(input logic s, input logic rv, input logic [31:0] rp,
                      input logic h, input logic [31:0] rd, input string tag);
    stall = s; redirect_valid = rv; redirect_pc = rp; imem_hit = h; imem_rdata = rd;
    #3;
    check_outputs(tag);
    model_clock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_reset();
    rstn = 1'b0; imem_hit = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #2;
    check32("rst.addr",  imem_addr, RST_PC);
    check32("rst.req",   {31'b0, imem_req}, 32'd0);
    check32("rst.hit",   {31'b0, hit_out}, 32'd0);
    check32("rst.adder", adder_out, RST_PC + 32'd4);
    check32("rst.instr", instruction_out, 32'hDEAD_BEEF);
    check32("rst.cnt",   miss_count, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    step(0, 0, 0, 1, 3, "seq0");
    step(0, 0, 0, 1, 3, "seq1");
    step(0, 0, 0, 0, 32'h11, "miss8a");
    step(0, 0, 0, 0, 32'h22, "miss8b");
    step(0, 0, 0, 0, 32'h33, "miss8c");
    check32("miss_held_addr", imem_addr, 32'd8);
    step(0, 0, 0, 1, 300, "fill8");
    check32("miss_count_one", miss_count, 32'd1);
    step(0, 0, 0, 1, 5, "seq12");
    step(0, 1, 32'h0000_0103, 1, 7, "redir_run");
    check32("redir_target", imem_addr, 32'h100);

    step(0, 1, 32'd20, 1, 8, "to20");
    step(0, 0, 0, 0, 9, "miss20");
    step(0, 1, 32'h200, 0, 9, "redir_in_miss");
    step(0, 0, 0, 0, 9, "miss_wait");
    step(0, 0, 0, 1, 10, "fill_pend");
    check32("pend_target", imem_addr, 32'h200);
    step(0, 0, 0, 1, 11, "after_pend");

    step(0, 1, 32'd24, 1, 12, "to24");
    step(1, 0, 0, 1, 13, "stall0");
    step(1, 0, 0, 1, 14, "stall1");
    check32("stall_hold", imem_addr, 32'd24);
    step(1, 1, 32'h40, 1, 15, "stall_redir");
    check32("stall_redir_pc", imem_addr, 32'h40);

    step(0, 1, 32'hFFFF_FFFC, 1, 16, "to_top");
    check32("wrap_adder", adder_out, 32'h0);
    step(0, 0, 0, 1, 17, "wrap");
    check32("wrap_addr", imem_addr, 32'h0);
    step(0, 0, 0, 1, 18, "fill4");
    step(0, 0, 0, 0, 19, "miss4");
    step(0, 1, 32'h80, 0, 20, "pend80");

    // Asynchronous reset in the middle of a miss with a redirect pending.
    #2;
    rstn = 1'b0;
    #1;
    check32("arst.addr", imem_addr, RST_PC);
    check32("arst.req",  {31'b0, imem_req}, 32'd0);
    check32("arst.hit",  {31'b0, hit_out}, 32'd0);
    check32("arst.cnt",  miss_count, 32'd0);
    m_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    step(0, 0, 0, 1, 21, "post_reset");
    check32("post_reset_addr", imem_addr, RST_PC + 32'd4);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom,
           $urandom_range(0, 9) < 7, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
